// File: rtl/vr_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vr_rr_arbiter
//  Purpose  : N-to-1 round-robin arbiter with packet locking in front of a
//             valid/ready pipeline node. One requester wins per beat. The
//             grant is held until that requester's last beat. Accepted beats
//             go into a single registered output stage that also reports
//             the source index of each beat.
//  Ports    : clk, rst_n (async, active-low)
//             in_data[N*WIDTH]  requester payloads, channel i at [i*WIDTH +: WIDTH]
//             in_valid[N], in_last[N]  per-requester valid / end-of-packet
//             in_ready[N]       combinational, one-hot or zero
//             out_data, out_last, out_id, out_valid  registered output stage
//             out_ready         downstream ready
//  Revision : 1.0  initial release
// ============================================================================
module vr_rr_arbiter #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int IDW   = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   input  logic [N-1:0]       in_last,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_last,
   output logic [IDW-1:0]     out_id,
   output logic               out_valid,
   input  logic               out_ready
);

   typedef enum logic [0:0] {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr, ptr_nxt;
   logic [IDW-1:0]   owner, owner_nxt;
   logic [IDW-1:0]   winner;
   logic             found;
   logic             load_en;
   logic             fire;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last;

   // Output stage can take a beat when empty or draining this cycle.
   assign load_en = ~out_valid | out_ready;

   // Winner selection. In ARB the search starts at ptr and wraps at N-1;
   // scanning from the far end down lets the closest requester overwrite
   // earlier candidates, so no priority chain beyond one loop is needed.
   always_comb begin : winner_search
      int idx;
      winner = ptr;
      found  = 1'b0;
      idx    = 0;
      if (state == ST_LOCK) begin
         winner = owner;
         for (int i = 0; i < N; i++) begin
            if (owner == IDW'(i)) found = in_valid[i];
         end
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (in_valid[idx]) begin
               winner = IDW'(idx);
               found  = 1'b1;
            end
         end
      end
   end

   // rst_n gates the grant so in_ready stays low while reset is held.
   assign fire = found & load_en & rst_n;

   for (genvar g = 0; g < N; g++) begin : g_ready
      assign in_ready[g] = fire & (winner == IDW'(g));
   end

   always_comb begin : payload_mux
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (winner == IDW'(i)) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
            sel_last = in_last[i];
         end
      end
   end

   always_comb begin : fsm_next
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      if (fire) begin
         case (state)
            ST_ARB: begin
               if (sel_last) begin
                  ptr_nxt = (winner == LAST_ID) ? '0 : winner + IDW'(1);
               end else begin
                  state_nxt = ST_LOCK;
                  owner_nxt = winner;
               end
            end
            ST_LOCK: begin
               if (sel_last) begin
                  state_nxt = ST_ARB;
                  ptr_nxt   = (owner == LAST_ID) ? '0 : owner + IDW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
      if (!rst_n) begin
         state <= ST_ARB;
         ptr   <= '0;
         owner <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : out_stage
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_id    <= '0;
      end else if (fire) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_last  <= sel_last;
         out_id    <= winner;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vr_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vr_rr_arbiter
//  Purpose  : Self-checking bench for vr_rr_arbiter (N=4 main instance plus
//             an N=3 instance for pointer wrap). Table vectors, hand-written
//             corner sequences and random traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vr_rr_arbiter;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int IDW   = 2;
   localparam int W3    = 8;
   localparam int N3    = 3;
   localparam int IDW3  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N*WIDTH-1:0] in_data  = '0;
   logic [N-1:0]       in_valid = '0;
   logic [N-1:0]       in_last  = '0;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_last;
   logic [IDW-1:0]     out_id;
   logic               out_valid;
   logic               out_ready = 1'b1;

   logic [N3*W3-1:0]   d3_data  = '0;
   logic [N3-1:0]      d3_valid = '0;
   logic [N3-1:0]      d3_last  = '0;
   logic [N3-1:0]      d3_ready;
   logic [W3-1:0]      d3_odata;
   logic               d3_olast;
   logic [IDW3-1:0]    d3_oid;
   logic               d3_ovalid;

   vr_rr_arbiter #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_last(out_last), .out_id(out_id),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   vr_rr_arbiter #(.WIDTH(W3), .N(N3), .IDW(IDW3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_data(d3_data), .in_valid(d3_valid), .in_last(d3_last), .in_ready(d3_ready),
      .out_data(d3_odata), .out_last(d3_olast), .out_id(d3_oid),
      .out_valid(d3_ovalid), .out_ready(1'b1)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int               m_ptr, m_owner, m_oid;
   bit               m_lock, m_ov, m_ol;
   logic [WIDTH-1:0] m_od;
   logic [N-1:0]     last_fire;

   task automatic model_reset();
      m_ptr = 0; m_owner = 0; m_lock = 0;
      m_ov = 0; m_ol = 0; m_od = '0; m_oid = 0;
   endtask

   // Who would be granted, ignoring output-stage space: -1 for nobody.
   function automatic int m_winner();
      if (m_lock) return in_valid[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   // Called at posedge+1 after inputs are set; ends at the next posedge+1.
   task automatic step(input string tag);
      int w;
      bit room;
      logic [N-1:0] er;
      #3;
      w    = m_winner();
      room = !m_ov || out_ready;
      er   = '0;
      if (w >= 0 && room) er[w] = 1'b1;
      check({tag, " in_ready"}, in_ready, er);
      last_fire = er;
      @(posedge clk); #1;
      if (er != '0) begin
         m_ov  = 1;
         m_od  = in_data[w*WIDTH +: WIDTH];
         m_ol  = in_last[w];
         m_oid = w;
         if (m_lock) begin
            if (in_last[w]) begin
               m_lock = 0;
               m_ptr  = (m_owner + 1) % N;
            end
         end else if (!in_last[w]) begin
            m_lock  = 1;
            m_owner = w;
         end else begin
            m_ptr = (w + 1) % N;
         end
      end else if (out_ready) begin
         m_ov = 0;
      end
      check({tag, " out_valid"}, out_valid, m_ov);
      check({tag, " out_data"},  out_data,  m_od);
      check({tag, " out_last"},  out_last,  m_ol);
      check({tag, " out_id"},    out_id,    m_oid);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = '0;
      in_last   = '0;
      out_ready = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [WIDTH-1:0] pay(input int i);
      return 32'hA0A0_0000 + i;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [N-1:0] v;
      logic [N-1:0] l;
      logic         ordy;
      logic [N-1:0] er;
      logic         eov;
      int           eid;
   } vec_t;

   vec_t tbl[15];

   task automatic d3_beat(input string tag, input logic [N3-1:0] v,
                          input logic [N3-1:0] er, input int eid);
      d3_valid = v;
      d3_last  = '1;
      #3;
      check({tag, " d3_ready"}, d3_ready, er);
      @(posedge clk); #1;
      check({tag, " d3_valid"}, d3_ovalid, 1'b1);
      check({tag, " d3_id"},    d3_oid,    eid);
      check({tag, " d3_data"},  d3_odata,  8'h30 + eid);
   endtask

   initial begin
      // rotation: all valid, single beats
      for (int i = 0; i < 8; i++)
         tbl[i] = '{v: 4'hF, l: 4'hF, ordy: 1'b1, er: 4'(1 << (i % 4)), eov: 1'b1, eid: i % 4};
      // lock on channel 0 for three beats, then channel 1 gets its turn
      tbl[8]  = '{4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 0};
      tbl[9]  = '{4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 0};
      tbl[10] = '{4'hF, 4'h1, 1'b1, 4'b0001, 1'b1, 0};
      tbl[11] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 1};
      // channel 2 locks, drops valid mid-packet (nobody granted), resumes
      tbl[12] = '{4'hF, 4'h0, 1'b1, 4'b0100, 1'b1, 2};
      tbl[13] = '{4'hB, 4'h0, 1'b1, 4'b0000, 1'b0, 0};
      tbl[14] = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2};

      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = pay(i);
      for (int i = 0; i < N3; i++) d3_data[i*W3 +: W3] = 8'h30 + i;
      model_reset();

      // ---- reset held: outputs idle, in_ready forced low ----
      in_valid = 4'hF;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #4;
         check("rst in_ready",  in_ready,  4'h0);
         check("rst out_valid", out_valid, 1'b0);
         check("rst out_id",    out_id,    2'd0);
      end
      in_valid = 4'h0;
      @(posedge clk); #4;
      check("idle out_valid", out_valid, 1'b0);
      check("idle in_ready",  in_ready,  4'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = 4'b0001;
      in_last  = 4'b0001;
      step("release");

      // ---- table: rotation and locking ----
      do_reset();
      for (int i = 0; i < 15; i++) begin
         in_valid  = tbl[i].v;
         in_last   = tbl[i].l;
         out_ready = tbl[i].ordy;
         #3;
         check($sformatf("tbl%0d ready", i), in_ready, tbl[i].er);
         step($sformatf("tbl%0d", i));
         check($sformatf("tbl%0d ovalid", i), out_valid, tbl[i].eov);
         if (tbl[i].eov) begin
            check($sformatf("tbl%0d oid", i),   out_id,   tbl[i].eid);
            check($sformatf("tbl%0d odata", i), out_data, pay(tbl[i].eid));
         end
      end

      // ---- backpressure: beat from channel 2 held for 5 cycles ----
      in_valid  = 4'hF;
      in_last   = 4'hF;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step("bp hold");
         check("bp frozen id", out_id, 2'd2);
         check("bp frozen valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      step("bp release");
      check("bp next id", out_id, 2'd3);
      check("bp next data", out_data, pay(3));

      // ---- random traffic against the model ----
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (last_fire[i] || !in_valid[i]) begin
               if ($urandom_range(9) < 6) begin
                  in_valid[i] = 1'b1;
                  in_data[i*WIDTH +: WIDTH] = $urandom;
                  in_last[i]  = ($urandom_range(2) == 0);
               end else begin
                  in_valid[i] = 1'b0;
               end
            end
         end
         out_ready = ($urandom_range(3) != 0);
         step("rand");
      end

      // ---- reset in the middle of a channel-2 packet ----
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = pay(i);
      do_reset();
      in_valid = 4'b0100;
      in_last  = 4'b0000;
      step("rm beat1");
      step("rm beat2");
      #3;
      rst_n = 1'b0;
      #1;
      check("rm out_valid", out_valid, 1'b0);
      check("rm in_ready",  in_ready,  4'h0);
      model_reset();
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = 4'b0110;
      in_last  = 4'b0110;
      step("rm after");
      check("rm grant id", out_id, 2'd1);

      // ---- N=3 pointer wrap ----
      in_valid = '0;
      d3_beat("w3 a", 3'b001, 3'b001, 0);
      d3_beat("w3 b", 3'b010, 3'b010, 1);
      d3_beat("w3 c", 3'b101, 3'b100, 2);
      d3_beat("w3 d", 3'b101, 3'b001, 0);
      d3_beat("w3 e", 3'b101, 3'b100, 2);
      d3_valid = '0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
